serial_addsub: RTL

Parametrised digit-serial adder/subtractor, the multi-cycle successor of the team's 4-bit ripple-carry full-adder chain. Processes a WIDTH-bit operand pair DIGIT bits per clock, LSB digit first, through one DIGIT-wide ripple stage and a registered carry. Adds a subtract mode, signed-overflow detection and a start/busy/done handshake. Used where area matters more than latency, such as wide accumulators and address arithmetic in slow control paths.

---
 rtl/serial_addsub.sv | 161 ++++++++++++++++
 1 files changed

// File: rtl/serial_addsub.sv
// serial_addsub
// Digit-serial adder/subtractor. A WIDTH-bit operand pair is processed DIGIT
// bits per clock, least significant digit first, through a single DIGIT-wide
// adder stage and a registered carry. An operation takes WIDTH/DIGIT clocks
// after the accepting edge. The result, carry-out and signed overflow are
// reported together with a one-cycle done pulse.
//
// Ports:
//   clk    rising-edge clock
//   rst    asynchronous reset, active-high
//   start  request a new operation (honoured only in IDLE or DONE)
//   sub    0: a + b + cin, 1: a - b (sampled with start)
//   a, b   WIDTH-bit operands (sampled with start)
//   cin    carry-in for add, ignored when sub=1
//   busy   high while the operation is running
//   done   one-cycle pulse, result outputs valid
//   sum    registered WIDTH-bit result
//   cout   carry out of the MSB (in subtract mode 1 means no borrow)
//   ovf    signed overflow (carry into MSB xor carry out of MSB)
//
// WIDTH must be a multiple of DIGIT.

module serial_addsub #(
    parameter int WIDTH = 16,
    parameter int DIGIT = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int NDIG = WIDTH / DIGIT;
    localparam int CW   = (NDIG > 1) ? $clog2(NDIG) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } stateT;

    stateT            stateReg;
    stateT            stateNext;

    logic [WIDTH-1:0] shiftA;
    logic [WIDTH-1:0] shiftB;
    logic [WIDTH-1:0] shiftRes;
    logic [WIDTH-1:0] resNext;
    logic             carry;
    logic [CW-1:0]    digitCnt;

    logic [DIGIT-1:0] digitA;
    logic [DIGIT-1:0] digitB;
    logic [DIGIT-1:0] digitSum;
    logic             digitCout;
    logic             msbCarryIn;
    logic             lastDigit;
    logic             accept;

    // The single ripple stage: low digit of each operand plus the carry
    // left over from the previous digit.
    always_comb begin
        digitA                 = shiftA[DIGIT-1:0];
        digitB                 = shiftB[DIGIT-1:0];
        {digitCout, digitSum}  = {1'b0, digitA} + {1'b0, digitB} + {{DIGIT{1'b0}}, carry};
        // The carry that entered the top bit of this digit is recovered from
        // that bit's sum and operand bits; on the final digit it is the carry
        // into the word MSB used for overflow detection.
        msbCarryIn             = digitSum[DIGIT-1] ^ digitA[DIGIT-1] ^ digitB[DIGIT-1];
        // New digit enters at the MSB end; written as a shift/or so it stays
        // legal when DIGIT equals WIDTH.
        resNext                = (shiftRes >> DIGIT) | (WIDTH'(digitSum) << (WIDTH - DIGIT));
        lastDigit              = (digitCnt == CW'(NDIG - 1));
        accept                 = start && ((stateReg == IDLE) || (stateReg == DONE));
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stateReg <= IDLE;
        end else begin
            stateReg <= stateNext;
        end
    end

    // Next-state logic. DONE lasts exactly one cycle, which is what makes
    // done a single-cycle pulse and lets start in that cycle chain the next
    // operation without an idle gap.
    always_comb begin
        stateNext = stateReg;
        case (stateReg)
            IDLE: begin
                if (start) begin
                    stateNext = RUN;
                end
            end
            RUN: begin
                if (lastDigit) begin
                    stateNext = DONE;
                end
            end
            DONE: begin
                if (start) begin
                    stateNext = RUN;
                end else begin
                    stateNext = IDLE;
                end
            end
            default: begin
                stateNext = IDLE;
            end
        endcase
    end

    // Datapath. Subtraction is folded into the add by inverting b at accept
    // and forcing the initial carry to one. The visible result registers are
    // only loaded on the final digit so they hold steady while running.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shiftA   <= '0;
            shiftB   <= '0;
            shiftRes <= '0;
            carry    <= 1'b0;
            digitCnt <= '0;
            sum      <= '0;
            cout     <= 1'b0;
            ovf      <= 1'b0;
        end else if (accept) begin
            shiftA   <= a;
            shiftB   <= sub ? ~b : b;
            carry    <= sub ? 1'b1 : cin;
            digitCnt <= '0;
        end else if (stateReg == RUN) begin
            shiftA   <= shiftA >> DIGIT;
            shiftB   <= shiftB >> DIGIT;
            shiftRes <= resNext;
            carry    <= digitCout;
            digitCnt <= digitCnt + CW'(1);
            if (lastDigit) begin
                sum  <= resNext;
                cout <= digitCout;
                ovf  <= digitCout ^ msbCarryIn;
            end
        end
    end

    // Status outputs come straight from the state register.
    always_comb begin
        busy = (stateReg == RUN);
        done = (stateReg == DONE);
    end

endmodule
